// File: rtl/lfsr_prbs_checker.sv
// ---------------------------------------------------------------------------
// lfsr_prbs_checker
//
// Self-synchronising PRBS checker. Each received bit is predicted from the
// previous LFSR_WIDTH received bits through the Fibonacci feedback taps. The
// prediction is compared with the bit actually received, and the received
// bit (never the prediction) is shifted into the history. A corrupted input
// bit therefore flushes out of the history on its own after LFSR_WIDTH bits.
//
// Tap convention: LFSR_POLY bit i stands for the x^i term, with x^LFSR_WIDTH
// implicit. Bit b[n] is expected to equal the XOR of b[n-(LFSR_WIDTH-i)]
// over every set bit i. For the default x^31 + x^28 + 1 this gives
// b[n] = b[n-3] ^ b[n-31].
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   data_in       in   DATA_WIDTH received bits
//   data_in_valid in   qualifies data_in (no backpressure)
//   clear         in   synchronous clear of error_count, fill counter, lock FSM
//   error_out     out  per-bit mismatch, same bit order as data_in
//   error_valid   out  data_in_valid delayed by one cycle
//   locked        out  lock FSM is in LOCKED
//   error_count   out  saturating count of mismatched bits while locked
//
// LFSR_WIDTH must be at least 2, and COUNT_WIDTH must be at least as wide as
// the per-word popcount.
// ---------------------------------------------------------------------------
module lfsr_prbs_checker #(
  parameter int                    LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
  parameter bit                    REVERSE      = 1'b0,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    LOCK_COUNT   = 16,
  parameter int                    UNLOCK_COUNT = 4,
  parameter int                    COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_valid,
  input  logic                   clear,
  output logic [DATA_WIDTH-1:0]  error_out,
  output logic                   error_valid,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] error_count
);

  localparam int FILL   = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int FILL_W = $clog2(FILL + 1);
  localparam int PC_W   = $clog2(DATA_WIDTH + 1);

  typedef logic [COUNT_WIDTH:0] sum_t;
  typedef logic [PC_W-1:0]      pop_t;

  localparam logic [FILL_W-1:0] FILL_C       = FILL_W'(FILL);
  localparam logic [FILL_W-1:0] FILL_ONE     = FILL_W'(1);
  localparam logic [7:0]        LOCK_C       = 8'(LOCK_COUNT);
  localparam logic [7:0]        UNLOCK_C     = 8'(UNLOCK_COUNT);
  localparam logic [7:0]        RUN_ONE      = 8'd1;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Maps polynomial bit i onto the history slot holding b[n-(LFSR_WIDTH-i)].
  // History slot 0 is the newest bit, slot LFSR_WIDTH-1 the oldest.
  function automatic logic [LFSR_WIDTH-1:0] tap_mask_f(input logic [LFSR_WIDTH-1:0] poly);
    logic [LFSR_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      m[LFSR_WIDTH-1-i] = poly[i];
    end
    return m;
  endfunction

  // Even parity of the selected history bits: the predicted next bit.
  function automatic logic parity_f(input logic [LFSR_WIDTH-1:0] v);
    return ^v;
  endfunction

  // Number of set bits in a word.
  function automatic pop_t popcount_f(input logic [DATA_WIDTH-1:0] v);
    pop_t c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      c = c + pop_t'(v[i]);
    end
    return c;
  endfunction

  // Reverses bit order so that index 0 is always the earliest bit in time.
  function automatic logic [DATA_WIDTH-1:0] bit_rev_f(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = v[DATA_WIDTH-1-i];
    end
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] TAP_MASK = tap_mask_f(LFSR_POLY);

  // Registers
  logic [LFSR_WIDTH-1:0]  hist_r;
  logic [FILL_W-1:0]      fill_r;
  logic [7:0]             clean_cnt_r;
  logic [7:0]             bad_cnt_r;
  lock_state_t            state_r;
  logic [DATA_WIDTH-1:0]  error_out_r;
  logic                   error_valid_r;
  logic                   locked_r;
  logic [COUNT_WIDTH-1:0] error_count_r;

  // Combinational signals
  logic [DATA_WIDTH-1:0]  data_time_s;
  logic [DATA_WIDTH-1:0]  err_time_s;
  logic [DATA_WIDTH-1:0]  err_s;
  logic [LFSR_WIDTH-1:0]  hist_walk_s;
  logic [LFSR_WIDTH-1:0]  hist_nx_s;
  logic                   word_valid_s;
  logic                   fill_done_s;
  logic                   checked_s;
  logic                   word_clean_s;
  logic [DATA_WIDTH-1:0]  err_masked_s;
  pop_t                   pop_s;
  sum_t                   sum_s;
  logic [COUNT_WIDTH-1:0] count_nx_s;
  lock_state_t            state_nx_s;
  logic [7:0]             clean_nx_s;
  logic [7:0]             bad_nx_s;

  // Unrolled per-bit prediction: later bits of a word see earlier ones.
  always_comb begin
    data_time_s = '0;
    err_time_s  = '0;
    hist_walk_s = hist_r;
    if (REVERSE) begin
      data_time_s = data_in;
    end else begin
      data_time_s = bit_rev_f(data_in);
    end
    for (int k = 0; k < DATA_WIDTH; k++) begin
      err_time_s[k] = data_time_s[k] ^ parity_f(hist_walk_s & TAP_MASK);
      hist_walk_s   = {hist_walk_s[LFSR_WIDTH-2:0], data_time_s[k]};
    end
    hist_nx_s = hist_walk_s;
    if (REVERSE) begin
      err_s = err_time_s;
    end else begin
      err_s = bit_rev_f(err_time_s);
    end
  end

  // Word qualification, fill masking and saturating error accumulation.
  always_comb begin
    word_valid_s = data_in_valid & ~clear;
    fill_done_s  = (fill_r == FILL_C);
    checked_s    = word_valid_s & fill_done_s;
    word_clean_s = (err_s == '0);
    if (checked_s) begin
      err_masked_s = err_s;
    end else begin
      err_masked_s = '0;
    end
    pop_s = popcount_f(err_s);
    sum_s = {1'b0, error_count_r} + sum_t'(pop_s);
    if (sum_s[COUNT_WIDTH]) begin
      count_nx_s = '1;
    end else begin
      count_nx_s = sum_s[COUNT_WIDTH-1:0];
    end
  end

  // Lock FSM next state and run counters; only fill-complete words count.
  always_comb begin
    state_nx_s = state_r;
    clean_nx_s = clean_cnt_r;
    bad_nx_s   = bad_cnt_r;
    if (clear) begin
      state_nx_s = HUNT;
      clean_nx_s = 8'd0;
      bad_nx_s   = 8'd0;
    end else if (checked_s) begin
      case (state_r)
        HUNT: begin
          if (word_clean_s) begin
            if ((clean_cnt_r + RUN_ONE) == LOCK_C) begin
              state_nx_s = LOCKED;
              clean_nx_s = 8'd0;
              bad_nx_s   = 8'd0;
            end else begin
              clean_nx_s = clean_cnt_r + RUN_ONE;
            end
          end else begin
            clean_nx_s = 8'd0;
          end
        end
        LOCKED: begin
          if (!word_clean_s) begin
            if ((bad_cnt_r + RUN_ONE) == UNLOCK_C) begin
              state_nx_s = HUNT;
              clean_nx_s = 8'd0;
              bad_nx_s   = 8'd0;
            end else begin
              bad_nx_s = bad_cnt_r + RUN_ONE;
            end
          end else begin
            bad_nx_s = 8'd0;
          end
        end
        default: begin
          state_nx_s = HUNT;
          clean_nx_s = 8'd0;
          bad_nx_s   = 8'd0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Lock FSM state register; locked follows the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= HUNT;
      clean_cnt_r <= 8'd0;
      bad_cnt_r   <= 8'd0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      clean_cnt_r <= clean_nx_s;
      bad_cnt_r   <= bad_nx_s;
      locked_r    <= (state_nx_s == LOCKED);
    end
  end

  // History, fill counter, registered error outputs and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r        <= '0;
      fill_r        <= '0;
      error_out_r   <= '0;
      error_valid_r <= 1'b0;
      error_count_r <= '0;
    end else begin
      error_valid_r <= data_in_valid;
      // A cleared word is still shifted in so the history stays continuous.
      if (data_in_valid) begin
        hist_r      <= hist_nx_s;
        error_out_r <= err_masked_s;
      end
      if (clear) begin
        fill_r <= '0;
      end else if (word_valid_s && !fill_done_s) begin
        fill_r <= fill_r + FILL_ONE;
      end
      // The unlocking word is still counted because state_r is LOCKED here.
      if (clear) begin
        error_count_r <= '0;
      end else if (checked_s && (state_r == LOCKED)) begin
        error_count_r <= count_nx_s;
      end
    end
  end

  assign error_out   = error_out_r;
  assign error_valid = error_valid_r;
  assign locked      = locked_r;
  assign error_count = error_count_r;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_prbs_checker
//
// Drives a PRBS31 stream (x^31 + x^28 + 1, seeded all ones, MSB first) into
// two checker instances: default parameters and a 4-bit error counter. The
// reference keeps the received bits as a plain bit queue and evaluates the
// recurrence b[n] = XOR of b[n-(31-i)] for each set polynomial bit i, then
// applies fill masking, run-length lock rules and saturating counting.
// ---------------------------------------------------------------------------
module tb_lfsr_prbs_checker;

  localparam int              W      = 31;
  localparam logic [W-1:0]    POLY   = 31'h10000001;
  localparam int              DW     = 8;
  localparam int              LOCKN  = 16;
  localparam int              UNLKN  = 4;
  localparam int              FILLN  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        data_in_valid;
  logic [7:0]  data_in;
  logic [7:0]  error_out;
  logic        error_valid;
  logic        locked;
  logic [31:0] error_count;
  logic [7:0]  error_out4;
  logic        error_valid4;
  logic        locked4;
  logic [3:0]  error_count4;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          gen_q[$];
  bit          rx_q[$];
  int          m_fill;
  bit          m_locked;
  int          m_clean;
  int          m_bad;
  longint      m_count;
  int          m_count4;
  bit          m_ev;
  logic [7:0]  m_eo;

  always #5 clk = ~clk;

  lfsr_prbs_checker dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .clear(clear), .error_out(error_out), .error_valid(error_valid),
    .locked(locked), .error_count(error_count)
  );

  lfsr_prbs_checker #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .clear(clear), .error_out(error_out4), .error_valid(error_valid4),
    .locked(locked4), .error_count(error_count4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next bit of a stream from the recurrence, given the bits so far.
  function automatic bit predict(input bit q[$]);
    bit e;
    int j;
    e = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (POLY[i]) begin
        j = q.size() - (W - i);
        if (j >= 0) e = e ^ q[j];
      end
    end
    return e;
  endfunction

  task automatic gen_word(output logic [7:0] w);
    bit nb;
    for (int k = 0; k < DW; k++) begin
      nb = predict(gen_q);
      gen_q.push_back(nb);
      w[DW-1-k] = nb;
    end
    while (gen_q.size() > 64) void'(gen_q.pop_front());
  endtask

  task automatic model_update(input bit v, input logic [7:0] d, input bit c, input bit r);
    logic [7:0] werr;
    int         p;
    bit         b;
    if (r) begin
      rx_q.delete();
      m_fill = 0; m_locked = 0; m_clean = 0; m_bad = 0;
      m_count = 0; m_count4 = 0; m_ev = 0; m_eo = 8'h00;
    end else begin
      m_ev = v;
      werr = 8'h00;
      if (v) begin
        for (int k = 0; k < DW; k++) begin
          b = d[DW-1-k];
          werr[DW-1-k] = b ^ predict(rx_q);
          rx_q.push_back(b);
        end
        while (rx_q.size() > 64) void'(rx_q.pop_front());
      end
      p = $countones(werr);
      if (c) begin
        m_fill = 0; m_locked = 0; m_clean = 0; m_bad = 0;
        m_count = 0; m_count4 = 0;
        if (v) m_eo = 8'h00;
      end else if (v) begin
        if (m_fill < FILLN) begin
          m_fill++;
          m_eo = 8'h00;
        end else begin
          m_eo = werr;
          if (m_locked) begin
            m_count  = (m_count + p > 64'd4294967295) ? 64'd4294967295 : m_count + p;
            m_count4 = (m_count4 + p > 15) ? 15 : m_count4 + p;
            if (p != 0) begin
              m_bad++;
              if (m_bad == UNLKN) begin m_locked = 0; m_clean = 0; end
            end else begin
              m_bad = 0;
            end
          end else begin
            if (p == 0) begin
              m_clean++;
              if (m_clean == LOCKN) begin m_locked = 1; m_bad = 0; m_clean = 0; end
            end else begin
              m_clean = 0;
            end
          end
        end
      end
    end
  endtask

  // One clock: drive, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit v, input logic [7:0] d, input bit c, input bit r);
    data_in_valid = v; data_in = d; clear = c; rst = r;
    model_update(v, d, c, r);
    @(posedge clk);
    #1;
    check_eq("error_valid", 64'(error_valid), 64'(m_ev));
    check_eq("error_out", 64'(error_out), 64'(m_eo));
    check_eq("locked", 64'(locked), 64'(m_locked));
    check_eq("error_count", 64'(error_count), 64'(m_count));
    check_eq("error_count4", 64'(error_count4), 64'(m_count4));
  endtask

  initial begin
    logic [7:0] w;
    int lock_word;
    int flip_bits;
    int since_flip;
    int flips;
    int waited;
    bit v;

    rst = 1'b1; clear = 1'b0; data_in_valid = 1'b0; data_in = 8'h00;
    for (int i = 0; i < W; i++) gen_q.push_back(1'b1);

    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b1);
    check_eq("rst_error_out", 64'(error_out), 64'h0);
    check_eq("rst_error_valid", 64'(error_valid), 64'h0);
    check_eq("rst_locked", 64'(locked), 64'h0);
    check_eq("rst_error_count", 64'(error_count), 64'h0);

    // Clean stream with a single flipped MSB in word 100
    lock_word = 0;
    flip_bits = 0;
    for (int n = 1; n <= 120; n++) begin
      gen_word(w);
      if (n == 100) w = w ^ 8'h80;
      step(1'b1, w, 1'b0, 1'b0);
      if (locked && lock_word == 0) lock_word = n;
      if (n >= 100 && n <= 104) flip_bits += $countones(error_out);
    end
    check_eq("lock_word", 64'(lock_word), 64'd20);
    check_eq("flip_err_bits", 64'(flip_bits), 64'd3);
    check_eq("flip_count", 64'(error_count), 64'd3);
    check_eq("flip_still_locked", 64'(locked), 64'd1);

    // Four words replaced by all ones drop lock
    for (int n = 0; n < 4; n++) begin
      gen_word(w);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
    end
    check_eq("burst_unlock", 64'(locked), 64'd0);
    waited = 0;
    while (!locked && waited < 60) begin
      gen_word(w);
      step(1'b1, w, 1'b0, 1'b0);
      waited++;
    end
    check_eq("burst_relock", 64'(locked), 64'd1);

    // Alternating valid with garbage on the idle cycles
    for (int i = 0; i < 20; i++) begin
      v = (i % 2 == 0);
      if (v) gen_word(w);
      else   w = 8'($urandom);
      step(v, w, 1'b0, 1'b0);
    end

    // Random valid gaps and spaced single-bit flips
    since_flip = 0;
    flips = 0;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(3, 0) != 0);
      if (v) begin
        gen_word(w);
        since_flip++;
        if (since_flip >= 10 && $urandom_range(2, 0) == 0) begin
          w = w ^ (8'h01 << $urandom_range(7, 0));
          since_flip = 0;
          flips++;
        end
      end else begin
        w = 8'($urandom);
      end
      step(v, w, 1'b0, 1'b0);
    end
    check_eq("flips_enough", 64'(flips >= 20), 64'd1);
    check_eq("sat_count4", 64'(error_count4), 64'hF);
    check_eq("random_locked", 64'(locked), 64'd1);

    // Clear mid-stream, then reset mid-stream
    gen_word(w);
    step(1'b1, w, 1'b1, 1'b0);
    check_eq("clear_count", 64'(error_count), 64'd0);
    check_eq("clear_locked", 64'(locked), 64'd0);
    for (int n = 0; n < 3; n++) begin
      gen_word(w);
      step(1'b1, w, 1'b0, 1'b0);
    end
    gen_word(w);
    step(1'b1, w, 1'b0, 1'b1);
    check_eq("rst_mid_count", 64'(error_count), 64'd0);
    check_eq("rst_mid_locked", 64'(locked), 64'd0);
    for (int n = 0; n < FILLN; n++) begin
      gen_word(w);
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      check_eq("fill_masked", 64'(error_out), 64'd0);
    end
    waited = 0;
    while (!locked && waited < 60) begin
      gen_word(w);
      step(1'b1, w, 1'b0, 1'b0);
      waited++;
    end
    check_eq("final_relock", 64'(locked), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
